// File: rtl/sp_fifo_ctrl.sv
// FIFO controller over a single-port SRAM with a registered head and an
// empty-FIFO fall-through bypass; reads always win the shared port.
module sp_fifo_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_ni,
   input  logic                  push_valid_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   output logic                  push_ready_o,
   output logic                  pop_valid_o,
   output logic [DATA_WIDTH-1:0] pop_data_o,
   input  logic                  pop_ready_i,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   output logic                  sram_we_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic pop_fire, slot_free, rd_grant, byp_ok, push_fire, wr_en, byp_load;

   assign pop_fire  = out_valid_q && pop_ready_i;
   assign slot_free = !out_valid_q || pop_fire;
   assign rd_grant  = (mem_cnt_q != '0) && !rd_pend_q && slot_free;
   assign byp_ok    = (mem_cnt_q == '0) && !rd_pend_q && slot_free;

   // Combinational on pop_ready_i: a pop this cycle can free the slot for a bypass.
   assign push_ready_o = byp_ok || (!rd_grant && (mem_cnt_q < DEPTH_C));
   assign push_fire    = push_valid_i && push_ready_o;
   assign wr_en        = push_fire && !byp_ok;
   assign byp_load     = push_fire && byp_ok;

   assign sram_we_o    = wr_en;
   assign sram_addr_o  = wr_en ? wr_ptr_q : rd_ptr_q;
   assign sram_wdata_o = push_data_i;

   assign pop_valid_o = out_valid_q;
   assign pop_data_o  = out_data_q;
   assign count_o     = mem_cnt_q + {{ADDR_WIDTH{1'b0}}, rd_pend_q}
                                  + {{ADDR_WIDTH{1'b0}}, out_valid_q};
   assign full_o      = (mem_cnt_q == DEPTH_C);
   assign empty_o     = (count_o == '0);

   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_cnt_d   = mem_cnt_q;
      rd_pend_d   = rd_grant;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (rd_grant) begin
         rd_ptr_d  = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
         mem_cnt_d = mem_cnt_q - 1'b1;
      end else if (wr_en) begin
         wr_ptr_d  = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
         mem_cnt_d = mem_cnt_q + 1'b1;
      end

      // A pending read implies the slot was freed when it was issued.
      if (rd_pend_q) begin
         out_data_d  = sram_rdata_i;
         out_valid_d = 1'b1;
      end else if (byp_load) begin
         out_data_d  = push_data_i;
         out_valid_d = 1'b1;
      end else if (pop_fire) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         rd_pend_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_cnt_q   <= mem_cnt_d;
         rd_pend_q   <= rd_pend_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule

// File: tb/tb_sp_fifo_ctrl.sv
// Directed bench for sp_fifo_ctrl (DEPTH=4, DATA_WIDTH=8) with a behavioural
// single-port SRAM and a pop monitor.
module tb_sp_fifo_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          push_valid = 1'b0;
   logic [DW-1:0] push_data = '0;
   logic          push_ready;
   logic          pop_valid;
   logic [DW-1:0] pop_data;
   logic          pop_ready = 1'b0;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic          sram_we;
   logic [DW-1:0] sram_rdata;
   logic [AW:0]   count;
   logic          full;
   logic          empty;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] got_q[$];
   logic [DW-1:0] mem[DEPTH];

   sp_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst_ni       (rst_ni),
      .push_valid_i (push_valid),
      .push_data_i  (push_data),
      .push_ready_o (push_ready),
      .pop_valid_o  (pop_valid),
      .pop_data_o   (pop_data),
      .pop_ready_i  (pop_ready),
      .sram_addr_o  (sram_addr),
      .sram_wdata_o (sram_wdata),
      .sram_we_o    (sram_we),
      .sram_rdata_i (sram_rdata),
      .count_o      (count),
      .full_o       (full),
      .empty_o      (empty)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      sram_rdata <= mem[sram_addr];
   end

   always @(negedge clk) begin
      if (rst_ni && pop_valid && pop_ready) got_q.push_back(pop_data);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [DW-1:0] d);
      push_valid = 1'b1;
      push_data  = d;
      @(negedge clk);
      check("push_rdy", push_ready, 1);
      tick();
      push_valid = 1'b0;
   endtask

   int pop_pat[32] = '{0,0,1,0,0,1,1,0,1,0,1,1,0,1,0,
                       1,1,0,1,1,0,1,0,1,1,1,0,1,1,0,1,1};

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, cyc, wr_wraps, last_wa, max_cnt;
      logic accepted;

      // Reset state
      @(negedge clk);
      check("rst_pop_valid", pop_valid, 0);
      check("rst_pop_data", pop_data, 0);
      check("rst_we", sram_we, 0);
      check("rst_count", count, 0);
      check("rst_full", full, 0);
      check("rst_empty", empty, 1);
      check("rst_push_ready", push_ready, 1);
      tick();
      rst_ni = 1'b1;
      tick();

      // 1: bypass into empty FIFO
      push_valid = 1'b1;
      push_data  = 8'hA5;
      @(negedge clk);
      check("t1_we", sram_we, 0);
      check("t1_ready", push_ready, 1);
      tick();
      push_valid = 1'b0;
      @(negedge clk);
      check("t1_valid", pop_valid, 1);
      check("t1_data", pop_data, 8'hA5);
      check("t1_count", count, 1);
      check("t1_empty", empty, 0);
      pop_ready = 1'b1;
      tick();
      pop_ready = 1'b0;
      @(negedge clk);
      check("t1_drained", empty, 1);
      tick();

      // 2: fill until SRAM full
      for (int i = 0; i < 5; i++) begin
         push_valid = 1'b1;
         push_data  = 8'(i + 1);
         @(negedge clk);
         check("t2_ready", push_ready, 1);
         check("t2_we", sram_we, (i == 0) ? 0 : 1);
         if (i > 0) begin
            check("t2_addr", sram_addr, i - 1);
            check("t2_wdata", sram_wdata, i + 1);
         end
         tick();
      end
      push_data = 8'h06;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("t2_full", full, 1);
         check("t2_count", count, 5);
         check("t2_stall", push_ready, 0);
         check("t2_we_stall", sram_we, 0);
         tick();
      end
      push_valid = 1'b0;

      // 3: drain, one pop every other cycle
      pop_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         check("t3_valid", pop_valid, (c % 2 == 0) ? 1 : 0);
         if (c % 2 == 0) check("t3_data", pop_data, 1 + c / 2);
         if (c % 2 == 0 && c < 8) begin
            check("t3_rd_we", sram_we, 0);
            check("t3_rd_addr", sram_addr, c / 2);
         end
         tick();
      end
      @(negedge clk);
      check("t3_count", count, 0);
      check("t3_empty", empty, 1);
      tick();
      pop_ready = 1'b0;

      // 4: read beats a simultaneous push
      push_one(8'h21);
      push_one(8'h22);
      push_one(8'h23);
      got_q.delete();
      push_valid = 1'b1;
      push_data  = 8'h24;
      pop_ready  = 1'b1;
      @(negedge clk);
      check("t4_stall", push_ready, 0);
      check("t4_we0", sram_we, 0);
      check("t4_rd_addr", sram_addr, 0);
      check("t4_head", pop_data, 8'h21);
      tick();
      @(negedge clk);
      check("t4_ready", push_ready, 1);
      check("t4_we1", sram_we, 1);
      check("t4_wr_addr", sram_addr, 2);
      tick();
      push_valid = 1'b0;
      for (int k = 0; k < 20 && got_q.size() < 4; k++) tick();
      check("t4_npop", got_q.size(), 4);
      for (int k = 0; k < 4 && k < got_q.size(); k++) check("t4_order", got_q[k], 8'h21 + k);
      pop_ready = 1'b0;
      tick();

      // 5: stream with irregular pop_ready, pointers wrap
      got_q.delete();
      idx = 0; cyc = 0; wr_wraps = 0; last_wa = -1; max_cnt = 0;
      while (got_q.size() < 10 && cyc < 80) begin
         push_valid = (idx < 10);
         push_data  = 8'(16 + idx);
         pop_ready  = pop_pat[cyc % 32][0];
         @(negedge clk);
         if (int'(count) > max_cnt) max_cnt = int'(count);
         accepted = push_valid && push_ready;
         if (sram_we) begin
            if (last_wa == 3 && sram_addr == 0) wr_wraps++;
            last_wa = int'(sram_addr);
         end
         tick();
         if (accepted) idx++;
         cyc++;
      end
      push_valid = 1'b0;
      pop_ready  = 1'b0;
      check("t5_npop", got_q.size(), 10);
      for (int k = 0; k < 10 && k < got_q.size(); k++) check("t5_order", got_q[k], 8'h10 + k);
      check("t5_cnt_le5", max_cnt <= 5, 1);
      check("t5_wr_wraps", wr_wraps >= 2, 1);

      // 6: async reset with a read pending
      push_one(8'h31);
      push_one(8'h32);
      push_one(8'h33);
      pop_ready = 1'b1;
      tick();
      pop_ready = 1'b0;
      @(negedge clk);
      check("t6_pre_count", count, 2);
      #2 rst_ni = 1'b0;
      #1;
      check("t6_rst_valid", pop_valid, 0);
      check("t6_rst_data", pop_data, 0);
      check("t6_rst_count", count, 0);
      check("t6_rst_empty", empty, 1);
      check("t6_rst_ready", push_ready, 1);
      check("t6_rst_we", sram_we, 0);
      tick();
      tick();
      rst_ni = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("t6_no_stale", pop_valid, 0);
         check("t6_cnt0", count, 0);
         tick();
      end
      push_valid = 1'b1;
      push_data  = 8'h77;
      @(negedge clk);
      check("t6_byp_we", sram_we, 0);
      check("t6_byp_ready", push_ready, 1);
      tick();
      push_valid = 1'b0;
      @(negedge clk);
      check("t6_valid", pop_valid, 1);
      check("t6_data", pop_data, 8'h77);
      check("t6_count", count, 1);
      pop_ready = 1'b1;
      tick();
      pop_ready = 1'b0;
      @(negedge clk);
      check("t6_empty", empty, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
